// File: rtl/stack_host_ctrl.sv
// Host-side controller for a pin-level stack peripheral: turns push/pop commands into
// strobe / bus-drive / done-handshake sequences and returns one response per command.
module stack_host_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_op,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [1:0]        o_rsp_err,
    output logic [4:0]        o_depth,
    output logic              o_stk_push,
    output logic              o_stk_pop,
    output logic [DATA_W-1:0] o_stk_data_out,
    output logic              o_stk_data_oe,
    input  logic [DATA_W-1:0] i_stk_data_in,
    input  logic              i_stk_done,
    input  logic              i_stk_empty,
    input  logic              i_stk_full
);

    // One extra count of headroom: a done edge in the last allowed cycle still advances.
    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLo,
        StWaitHi,
        StResp
    } state_e;

    state_e            r_state;
    logic              r_op;
    logic [CntW-1:0]   r_wait_cnt;
    logic [CntW-1:0]   w_cnt_next;
    logic              w_timeout;
    logic              w_depth_max;

    assign w_cnt_next  = r_wait_cnt + CntW'(1);
    assign w_timeout   = (w_cnt_next >= CntW'(TIMEOUT));
    assign w_depth_max = (o_depth >= 5'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_op           <= 1'b0;
            r_wait_cnt     <= '0;
            o_cmd_ready    <= 1'b1;
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_rsp_err      <= 2'b00;
            o_depth        <= 5'd0;
            o_stk_push     <= 1'b0;
            o_stk_pop      <= 1'b0;
            o_stk_data_out <= '0;
            o_stk_data_oe  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_op        <= i_cmd_op;
                        o_cmd_ready <= 1'b0;
                        if (i_cmd_op && i_stk_full) begin
                            r_state     <= StResp;
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= '0;
                            o_rsp_err   <= 2'b01;
                        end else if (!i_cmd_op && i_stk_empty) begin
                            r_state     <= StResp;
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= '0;
                            o_rsp_err   <= 2'b10;
                        end else begin
                            r_state       <= StIssue;
                            r_wait_cnt    <= '0;
                            o_stk_push    <= i_cmd_op;
                            o_stk_pop     <= !i_cmd_op;
                            o_stk_data_oe <= i_cmd_op;
                            if (i_cmd_op) begin
                                o_stk_data_out <= i_cmd_data;
                            end
                        end
                    end
                end
                StIssue: begin
                    o_stk_push <= 1'b0;
                    o_stk_pop  <= 1'b0;
                    r_state    <= StWaitLo;
                end
                StWaitLo: begin
                    r_wait_cnt <= w_cnt_next;
                    if (!i_stk_done) begin
                        r_state <= StWaitHi;
                    end else if (w_timeout) begin
                        r_state       <= StResp;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_data    <= '0;
                        o_rsp_err     <= 2'b11;
                        o_stk_data_oe <= 1'b0;
                    end
                end
                StWaitHi: begin
                    r_wait_cnt <= w_cnt_next;
                    if (i_stk_done) begin
                        r_state       <= StResp;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_err     <= 2'b00;
                        o_stk_data_oe <= 1'b0;
                        if (r_op) begin
                            o_rsp_data <= '0;
                            if (!w_depth_max) begin
                                o_depth <= o_depth + 5'd1;
                            end
                        end else begin
                            o_rsp_data <= i_stk_data_in;
                            if (o_depth != 5'd0) begin
                                o_depth <= o_depth - 5'd1;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state       <= StResp;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_data    <= '0;
                        o_rsp_err     <= 2'b11;
                        o_stk_data_oe <= 1'b0;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_state     <= StIdle;
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
